spi_mstr_gen: RTL

//  Parametrised SPI master; next generation of the 16-bit single-slave master that talks to the ADC128S.

---
 rtl/spi_mstr_gen_pkg.sv | 23 ++
 rtl/spi_mstr_gen_if.sv | 21 ++
 rtl/spi_mstr_gen_sclk.sv | 45 ++++
 rtl/spi_mstr_gen.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/spi_mstr_gen_pkg.sv
// Shared types and helpers for the parametrised SPI master.
// Holds the frame state encoding and the small sizing functions used by the
// interface, the SCLK divider and the top level.
package spi_mstr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRONT = 2'd1,
        SHIFT = 2'd2,
        BACK  = 2'd3
    } state_t;

    // Number of clk cycles in half an SCLK period.
    function automatic int half_of(input int div_log2);
        return 1 << (div_log2 - 1);
    endfunction

    // Width of the slave-select index; never narrower than one bit.
    function automatic int ss_w_of(input int num_ss);
        return (num_ss > 1) ? $clog2(num_ss) : 1;
    endfunction

endpackage

// File: rtl/spi_mstr_gen_if.sv
// Command-side bus of the SPI master: a frame request (wrt/cmd/ss_sel) and
// its completion (done/rd_data). The control logic uses the master modport,
// the SPI master block uses the slave modport.
interface spi_mstr_gen_if #(
    parameter int WIDTH  = 16,
    parameter int NUM_SS = 1
);
    import spi_mstr_pkg::*;

    localparam int SS_W = ss_w_of(NUM_SS);

    logic             wrt;
    logic [WIDTH-1:0] cmd;
    logic [SS_W-1:0]  ss_sel;
    logic             done;
    logic [WIDTH-1:0] rd_data;

    modport master (output wrt, output cmd, output ss_sel, input done, input rd_data);
    modport slave  (input wrt, input cmd, input ss_sel, output done, output rd_data);

endinterface

// File: rtl/spi_mstr_gen_sclk.sv
// SCLK divider for the SPI master.
// While enabled, a free-running counter produces a 50% duty SCLK whose period
// is 2**DIV_LOG2 clk cycles. The strobes announce that SCLK will rise/fall on
// the coming clk edge so the frame logic can act in the same cycle.
// suppress_fall keeps SCLK high while still reporting the fall strobe, and
// restart re-phases the counter so the next fall comes half a period later.
module spi_sclk_gen #(
    parameter int DIV_LOG2 = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    input  logic suppress_fall,
    output logic sclk,
    output logic rise_imm,
    output logic fall_imm
);
    import spi_mstr_pkg::*;

    localparam int HALF = half_of(DIV_LOG2);

    logic [DIV_LOG2-1:0] cnt;

    assign rise_imm = en & (cnt == '0) & ~sclk;
    assign fall_imm = en & (cnt == DIV_LOG2'(HALF)) & sclk;

    // Divider counter and SCLK level; both park (count 0, SCLK high) while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else begin
            cnt <= restart ? DIV_LOG2'(1) : cnt + DIV_LOG2'(1);
            if (rise_imm)
                sclk <= 1'b1;
            else if (fall_imm && !suppress_fall)
                sclk <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_mstr_gen.sv
// Parametrised SPI master (SCLK idles high, MOSI changes on fall, MISO
// sampled on rise, MSB first) with per-frame slave selection.
// Optional feature macro: SPI_MSTR_BURST_EN adds a one-entry command hold
// register so a frame requested while busy follows the current one with the
// slave select kept low.
module spi_mstr_gen
    import spi_mstr_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DIV_LOG2 = 5,
    parameter int NUM_SS   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_mstr_gen_if.slave      bus,
    output logic               SCLK,
    output logic [NUM_SS-1:0]  SS_n,
    output logic               MOSI,
    input  logic               MISO
);

    localparam int SS_W  = ss_w_of(NUM_SS);
    localparam int BIT_W = $clog2(WIDTH);

    state_t            state;
    logic [WIDTH-1:0]  shift_reg;
    logic [WIDTH-1:0]  rd_q;
    logic [SS_W-1:0]   ss_q;
    logic [NUM_SS-1:0] ss_n_q;
    logic [NUM_SS-1:0] ss_dec;
    logic [BIT_W-1:0]  bit_cnt;
    logic              done_q;
    logic              sample;
    logic              rise_imm;
    logic              fall_imm;
    logic              sel_ok;
    logic              frame_end;
    logic              restart;

`ifdef SPI_MSTR_BURST_EN
    logic [WIDTH-1:0]  hold;
    logic              hold_full;
    assign restart = frame_end & hold_full;
`else
    assign restart = 1'b0;
`endif

    assign sel_ok    = (int'(bus.ss_sel) < NUM_SS);
    assign frame_end = (state == BACK) && fall_imm;

    assign MOSI        = shift_reg[WIDTH-1];
    assign SS_n        = ss_n_q;
    assign bus.done    = done_q;
    assign bus.rd_data = rd_q;

    spi_sclk_gen #(.DIV_LOG2(DIV_LOG2)) u_sclk (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (state != IDLE),
        .restart       (restart),
        .suppress_fall (state == BACK),
        .sclk          (SCLK),
        .rise_imm      (rise_imm),
        .fall_imm      (fall_imm)
    );

    // One-hot-low select pattern for the slave latched at frame start.
    always_comb begin
        ss_dec = '1;
        for (int i = 0; i < NUM_SS; i++)
            ss_dec[i] = (int'(ss_q) != i);
    end

    // Frame sequencer: owns the state, shift register, MISO sample, selects and done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            rd_q      <= '0;
            ss_q      <= '0;
            ss_n_q    <= '1;
            bit_cnt   <= '0;
            done_q    <= 1'b0;
            sample    <= 1'b0;
`ifdef SPI_MSTR_BURST_EN
            hold      <= '0;
            hold_full <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.wrt && sel_ok) begin
                        shift_reg <= bus.cmd;
                        ss_q      <= bus.ss_sel;
                        done_q    <= 1'b0;
                        bit_cnt   <= '0;
                        state     <= FRONT;
                    end
                end
                FRONT: begin
                    ss_n_q <= ss_dec;
                    done_q <= 1'b0;
                    if (fall_imm)
                        state <= SHIFT;
                end
                SHIFT: begin
                    if (rise_imm) begin
                        sample  <= MISO;
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        if (bit_cnt == BIT_W'(WIDTH - 1))
                            state <= BACK;
                    end
                    if (fall_imm)
                        shift_reg <= {shift_reg[WIDTH-2:0], sample};
                end
                BACK: begin
                    if (fall_imm) begin
                        rd_q   <= {shift_reg[WIDTH-2:0], sample};
                        done_q <= 1'b1;
`ifdef SPI_MSTR_BURST_EN
                        if (hold_full) begin
                            shift_reg <= hold;
                            hold_full <= 1'b0;
                            bit_cnt   <= '0;
                            state     <= FRONT;
                        end else begin
                            shift_reg <= {shift_reg[WIDTH-2:0], sample};
                            ss_n_q    <= '1;
                            state     <= IDLE;
                        end
`else
                        shift_reg <= {shift_reg[WIDTH-2:0], sample};
                        ss_n_q    <= '1;
                        state     <= IDLE;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef SPI_MSTR_BURST_EN
            if (state != IDLE && !frame_end && bus.wrt && !hold_full) begin
                hold      <= bus.cmd;
                hold_full <= 1'b1;
            end
`endif
        end
    end

endmodule
